// File: rtl/ram64_arbiter.sv
// Two-port round-robin arbiter in front of a single ram64 (combinational read, registered write).
// Define RAM_CLEAR_EN to zero all 64 words after every reset before accepting requests.
module ram64_arbiter #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_ack,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_ack,
  output logic [DATA_W-1:0] b_rdata,
  output logic              mem_load,
  output logic [ADDR_W-1:0] mem_addres,
  output logic [DATA_W-1:0] mem_data_in,
  input  logic [DATA_W-1:0] mem_data_out,
  output logic              init_done
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
`ifdef RAM_CLEAR_EN
    , CLEAR
`endif
  } state_t;

  state_t state;
  logic   grant_b;
  logic   last_grant_b;
  logic   pick_b;

  // B wins only when A is idle or when A was the previous winner
  assign pick_b = b_req && (!a_req || !last_grant_b);

`ifdef RAM_CLEAR_EN
  logic init_done_r;
  assign init_done = init_done_r;
`else
  assign init_done = 1'b1;
`endif

  // mem_addres/mem_data_in/mem_load double as the latched request, so ACCESS reads them directly
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
`ifdef RAM_CLEAR_EN
      state       <= CLEAR;
      init_done_r <= 1'b0;
`else
      state       <= IDLE;
`endif
      grant_b      <= 1'b0;
      last_grant_b <= 1'b1;
      a_ack        <= 1'b0;
      b_ack        <= 1'b0;
      a_rdata      <= '0;
      b_rdata      <= '0;
      mem_load     <= 1'b0;
      mem_addres   <= '0;
      mem_data_in  <= '0;
    end else begin
      a_ack <= 1'b0;
      b_ack <= 1'b0;
      case (state)
        IDLE: begin
          mem_load <= 1'b0;
          if (a_req || b_req) begin
            grant_b      <= pick_b;
            last_grant_b <= pick_b;
            mem_load     <= pick_b ? b_we    : a_we;
            mem_addres   <= pick_b ? b_addr  : a_addr;
            mem_data_in  <= pick_b ? b_wdata : a_wdata;
            state        <= ACCESS;
          end
        end
        ACCESS: begin
          if (!mem_load) begin
            if (grant_b) b_rdata <= mem_data_out;
            else         a_rdata <= mem_data_out;
          end
          mem_load <= 1'b0;
          if (grant_b) b_ack <= 1'b1;
          else         a_ack <= 1'b1;
          state <= DONE;
        end
        DONE: begin
          mem_load <= 1'b0;
          state    <= IDLE;
        end
`ifdef RAM_CLEAR_EN
        // First cycle arms the write at address 0; the cycle after address 63 finishes
        CLEAR: begin
          if (!mem_load) begin
            mem_load   <= 1'b1;
            mem_addres <= '0;
          end else if (mem_addres == '1) begin
            mem_load    <= 1'b0;
            init_done_r <= 1'b1;
            state       <= IDLE;
          end else begin
            mem_addres <= mem_addres + ADDR_W'(1);
          end
        end
`endif
        default: begin
          mem_load <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram64_arbiter.sv
// Directed bench for ram64_arbiter with a behavioural ram64 model (combinational read, clocked write).
// Expectations follow RAM_CLEAR_EN when the macro is defined.
module tb_ram64_arbiter;

  logic        clk;
  logic        rst;
  logic        a_req, a_we, b_req, b_we;
  logic [5:0]  a_addr, b_addr;
  logic [15:0] a_wdata, b_wdata;
  logic        a_ack, b_ack;
  logic [15:0] a_rdata, b_rdata;
  logic        mem_load;
  logic [5:0]  mem_addres;
  logic [15:0] mem_data_in, mem_data_out;
  logic        init_done;

  logic [15:0] ram [64];
  logic        preload;
  int          loadCount = 0;
  int          checks = 0;
  int          errors = 0;

  ram64_arbiter #(.ADDR_W(6), .DATA_W(16)) dut (
    .clk(clk), .rst(rst),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_ack(a_ack), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_ack(b_ack), .b_rdata(b_rdata),
    .mem_load(mem_load), .mem_addres(mem_addres), .mem_data_in(mem_data_in),
    .mem_data_out(mem_data_out), .init_done(init_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ram64 model: preload pattern 0x0100+addr, then ordinary clocked writes
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 64; i++) ram[i] <= 16'h0100 + 16'(i);
    end else if (mem_load) begin
      ram[mem_addres] <= mem_data_in;
    end
  end
  assign mem_data_out = ram[mem_addres];

  always @(negedge clk) if (mem_load) loadCount++;

  function automatic logic [15:0] initVal(input int addr);
`ifdef RAM_CLEAR_EN
    return 16'h0000 + 16'(addr * 0);
`else
    return 16'h0100 + 16'(addr);
`endif
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input bit port, input bit req, input bit we,
                               input logic [5:0] addr, input logic [15:0] wdata);
    if (!port) begin
      a_req = req; a_we = we; a_addr = addr; a_wdata = wdata;
    end else begin
      b_req = req; b_we = we; b_addr = addr; b_wdata = wdata;
    end
  endtask

  task automatic doReset(input string tag);
    int cyc;
    rst = 1'b1;
    applyStimulus(0, 0, 0, 6'd0, 16'h0);
    applyStimulus(1, 0, 0, 6'd0, 16'h0);
    repeat (2) @(negedge clk);
    checkOutput({tag, "_a_ack"}, 32'(a_ack), 32'd0);
    checkOutput({tag, "_b_ack"}, 32'(b_ack), 32'd0);
    checkOutput({tag, "_a_rdata"}, 32'(a_rdata), 32'd0);
    checkOutput({tag, "_b_rdata"}, 32'(b_rdata), 32'd0);
    checkOutput({tag, "_mem_load"}, 32'(mem_load), 32'd0);
    checkOutput({tag, "_mem_addres"}, 32'(mem_addres), 32'd0);
    checkOutput({tag, "_mem_data_in"}, 32'(mem_data_in), 32'd0);
`ifdef RAM_CLEAR_EN
    checkOutput({tag, "_init_done"}, 32'(init_done), 32'd0);
`else
    checkOutput({tag, "_init_done"}, 32'(init_done), 32'd1);
`endif
    rst = 1'b0;
`ifdef RAM_CLEAR_EN
    cyc = 0;
    while (!init_done && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    checkOutput({tag, "_clear_cycles"}, 32'(cyc), 32'd65);
`endif
  endtask

  // One transaction on one port with the other idle; req drops on the edge ending the ack cycle
  task automatic runTxn(input string tag, input bit port, input bit we,
                        input logic [5:0] addr, input logic [15:0] wdata);
    int cyc;
    int loads0;
    bit seenOther;
    cyc = 0;
    seenOther = 0;
    @(negedge clk);
    loads0 = loadCount;
    applyStimulus(port, 1, we, addr, wdata);
    do begin
      @(negedge clk);
      cyc++;
      if (port ? a_ack : b_ack) seenOther = 1;
    end while (!(port ? b_ack : a_ack) && cyc < 20);
    checkOutput({tag, "_latency"}, 32'(cyc), 32'd2);
    checkOutput({tag, "_other_ack"}, 32'(seenOther), 32'd0);
    @(posedge clk);
    #1 applyStimulus(port, 0, we, addr, wdata);
    @(negedge clk);
    checkOutput({tag, "_load_cycles"}, 32'(loadCount - loads0), we ? 32'd1 : 32'd0);
  endtask

  initial begin
    int idx;
    int n;
    preload = 1'b1;
    rst = 1'b1;
    applyStimulus(0, 0, 0, 6'd0, 16'h0);
    applyStimulus(1, 0, 0, 6'd0, 16'h0);
    repeat (2) @(negedge clk);
    preload = 1'b0;
    doReset("rst0");

    // Both ports request together after reset and hold: A first, then strict alternation
    @(negedge clk);
    applyStimulus(0, 1, 0, 6'd5, 16'h0);
    applyStimulus(1, 1, 0, 6'd6, 16'h0);
    idx = 0;
    n = 0;
    while (n < 6 && idx < 40) begin
      @(negedge clk);
      idx++;
      if (a_ack || b_ack) begin
        checkOutput($sformatf("contend%0d_port", n), 32'(b_ack), 32'(n % 2));
        checkOutput($sformatf("contend%0d_cycle", n), 32'(idx), 32'(2 + 3 * n));
        n++;
      end
    end
    checkOutput("contend_count", 32'(n), 32'd6);
    @(posedge clk);
    #1;
    applyStimulus(0, 0, 0, 6'd0, 16'h0);
    applyStimulus(1, 0, 0, 6'd0, 16'h0);
    checkOutput("contend_a_rdata", 32'(a_rdata), 32'(initVal(5)));
    checkOutput("contend_b_rdata", 32'(b_rdata), 32'(initVal(6)));

    runTxn("wrA5", 0, 1, 6'd5, 16'h1234);
    checkOutput("wrA5_rdata_held", 32'(a_rdata), 32'(initVal(5)));
    runTxn("rdA5", 0, 0, 6'd5, 16'h0);
    checkOutput("rdA5_rdata", 32'(a_rdata), 32'h1234);

    runTxn("wrB63", 1, 1, 6'd63, 16'hBEEF);
    checkOutput("wrB63_rdata_held", 32'(b_rdata), 32'(initVal(6)));
    runTxn("rdA63", 0, 0, 6'd63, 16'h0);
    checkOutput("rdA63_rdata", 32'(a_rdata), 32'hBEEF);
    runTxn("rdB5", 1, 0, 6'd5, 16'h0);
    checkOutput("rdB5_rdata", 32'(b_rdata), 32'h1234);

    // Reset lands in the middle of the ACCESS cycle of a write
    @(negedge clk);
    applyStimulus(0, 1, 1, 6'd10, 16'hFFFF);
    @(posedge clk);
    #2 checkOutput("midwr_load_before", 32'(mem_load), 32'd1);
    rst = 1'b1;
    applyStimulus(0, 0, 0, 6'd0, 16'h0);
    #1 checkOutput("midwr_load_after", 32'(mem_load), 32'd0);
    doReset("rst1");
    @(negedge clk);
    checkOutput("midwr_no_ack", 32'(a_ack), 32'd0);
    runTxn("rdA10", 0, 0, 6'd10, 16'h0);
    checkOutput("rdA10_rdata", 32'(a_rdata), 32'(initVal(10)));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
